// File: rtl/seg_pkg.sv
`timescale 1ns/1ps
// Shared seven-segment constants, display FSM state type and a
// compile-time power-of-ten helper for the overflow limit.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CONVERT = 1'b1
  } state_e;

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int k = 0; k < n; k++) p = p * 32'd10;
    return p;
  endfunction

endpackage

// File: rtl/seg_digit_decode.sv
`timescale 1ns/1ps
// Combinational BCD nibble to seven-segment pattern (bits 6..0 = g..a).
// Non-decimal nibbles produce a dark digit.
module seg_digit_decode
  import seg_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/multi_digit_display.sv
`timescale 1ns/1ps
// Multiplexed decimal display: sequential double-dabble conversion of a
// binary value, atomic display update, and a free-running digit scanner.
module multi_digit_display
  import seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int VALUE_W  = 14,
  parameter int SCAN_DIV = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic               blank_lz,
  input  logic [DIGITS-1:0]  dp_mask,
  output logic [7:0]         segment_data,
  output logic [DIGITS-1:0]  digit_sel,
  output logic               busy,
  output logic               done
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(VALUE_W);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [31:0] MAX_VAL = pow10(DIGITS) - 32'd1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic [VALUE_W-1:0] shift_q, shift_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d, bcd_adj;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         seg_q, seg_d;
  logic [DIGITS-1:0]  sel_q, sel_d;

  logic [DIGITS-1:0]  nib_zero;
  logic [DIGITS-1:0]  upper_zero;
  logic               zero_run;
  logic [3:0]         cur_nibble;
  logic [6:0]         cur_dec;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_nib_zero
      assign nib_zero[gi] = (disp_q[4*gi +: 4] == 4'd0);
    end
  endgenerate

  // upper_zero[i]: this digit and every more significant digit are zero
  always_comb begin
    upper_zero = '0;
    zero_run   = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run      = zero_run & nib_zero[k];
      upper_zero[k] = zero_run;
    end
  end

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    ovf_pend_d = ovf_pend_q;
    disp_d     = disp_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    bcd_adj    = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    case (state_q)
      ST_IDLE: begin
        if (load) begin
          state_d    = ST_CONVERT;
          step_d     = '0;
          shift_d    = value;
          bcd_d      = '0;
          ovf_pend_d = (32'(value) > MAX_VAL);
        end
      end
      ST_CONVERT: begin
        bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[VALUE_W-1]};
        shift_d = {shift_q[VALUE_W-2:0], 1'b0};
        step_d  = step_q + 1'b1;
        // Final shift lands straight in the display registers
        if (step_q == CNT_W'(VALUE_W - 1)) begin
          state_d = ST_IDLE;
          disp_d  = bcd_d;
          ovf_d   = ovf_pend_q;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  seg_digit_decode u_decode (
    .nibble_i (cur_nibble),
    .seg_o    (cur_dec)
  );

  always_comb begin
    pre_d = pre_q + 1'b1;
    idx_d = idx_q;
    if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
      pre_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
    cur_nibble = disp_q[{idx_q, 2'b00} +: 4];
    if (ovf_q)
      seg_d[6:0] = SEG_DASH;
    else if (blank_lz && (idx_q != '0) && upper_zero[idx_q])
      seg_d[6:0] = SEG_BLANK;
    else
      seg_d[6:0] = cur_dec;
    seg_d[7] = dp_mask[idx_q];
    sel_d    = DIGITS'(1) << idx_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      shift_q    <= '0;
      bcd_q      <= '0;
      ovf_pend_q <= 1'b0;
      disp_q     <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      pre_q      <= '0;
      idx_q      <= '0;
      seg_q      <= 8'h00;
      sel_q      <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      ovf_pend_q <= ovf_pend_d;
      disp_q     <= disp_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      seg_q      <= seg_d;
      sel_q      <= sel_d;
    end
  end

  assign busy         = (state_q == ST_CONVERT);
  assign done         = done_q;
  assign segment_data = seg_q;
  assign digit_sel    = sel_q;

endmodule

// File: tb/tb_multi_digit_display.sv
`timescale 1ns/1ps
// Directed and randomized bench for multi_digit_display: conversion timing,
// load handling, reset abort and scanned segment output against a decimal model.
module tb_multi_digit_display;

  localparam int DIGITS   = 4;
  localparam int VALUE_W  = 14;
  localparam int SCAN_DIV = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [VALUE_W-1:0] value;
  logic               load;
  logic               blank_lz;
  logic [DIGITS-1:0]  dp_mask;
  logic [7:0]         segment_data;
  logic [DIGITS-1:0]  digit_sel;
  logic               busy;
  logic               done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  multi_digit_display #(
    .DIGITS   (DIGITS),
    .VALUE_W  (VALUE_W),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .value        (value),
    .load         (load),
    .blank_lz     (blank_lz),
    .dp_mask      (dp_mask),
    .segment_data (segment_data),
    .digit_sel    (digit_sel),
    .busy         (busy),
    .done         (done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  // Decimal reference: digit i of v, with blanking / overflow rules applied
  function automatic logic [7:0] exp_seg(input int unsigned v, input int i, input bit lz,
                                         input logic [DIGITS-1:0] dp);
    logic [6:0]  tbl [10];
    int unsigned p;
    logic [6:0]  s;
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    if (v > 9999) s = 7'h40;
    else if (lz && i > 0 && v < p) s = 7'h00;
    else s = tbl[(v / p) % 10];
    return {dp[i], s};
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_load(input int unsigned v, input bit mid_load, input int unsigned v2);
    int n;
    value = VALUE_W'(v);
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    check("busy_start", busy, 1);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      if (mid_load && n == 5) begin
        value = VALUE_W'(v2);
        load  = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(negedge clk);
    end
    load = 1'b0;
    check("busy_len", n, VALUE_W);
    check("done_pulse", done, 1);
  endtask

  task automatic finish_done();
    @(negedge clk);
    check("done_single", done, 0);
  endtask

  task automatic check_display(input int unsigned v, input bit lz, input logic [DIGITS-1:0] dp);
    int idx;
    for (int k = 0; k < DIGITS * SCAN_DIV; k++) begin
      @(negedge clk);
      idx = -1;
      for (int j = 0; j < DIGITS; j++)
        if (digit_sel == DIGITS'(1 << j)) idx = j;
      check("sel_onehot", {31'd0, idx >= 0}, 1);
      if (idx >= 0) check($sformatf("seg_v%0d_d%0d", v, idx), segment_data, exp_seg(v, idx, lz, dp));
    end
  endtask

  initial begin
    int unsigned rv;
    int done_seen;
    rst_n    = 1'b0;
    load     = 1'b0;
    value    = '0;
    blank_lz = 1'b0;
    dp_mask  = '0;
    repeat (3) @(negedge clk);
    check("rst_sel", digit_sel, 0);
    check("rst_seg", segment_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);

    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      check($sformatf("scan_sel_%0d", k), digit_sel, 32'(1 << (((k - 1) / 4) % 4)));
      check("scan_seg", segment_data, 8'h3F);
    end

    run_load(1234, 0, 0);
    finish_done();
    check_display(1234, 0, '0);

    blank_lz = 1'b1;
    run_load(7, 0, 0);
    finish_done();
    check_display(7, 1, '0);
    blank_lz = 1'b0;
    repeat (2) @(negedge clk);
    check_display(7, 0, '0);

    dp_mask = 4'b0100;
    run_load(12000, 0, 0);
    finish_done();
    check_display(12000, 0, 4'b0100);
    blank_lz = 1'b1;
    repeat (2) @(negedge clk);
    check_display(12000, 1, 4'b0100);

    dp_mask = '0;
    run_load(9999, 0, 0);
    finish_done();
    check_display(9999, 1, '0);
    run_load(10000, 0, 0);
    finish_done();
    check_display(10000, 1, '0);
    run_load(0, 0, 0);
    finish_done();
    check_display(0, 1, '0);

    blank_lz = 1'b0;
    run_load(1234, 1, 5555);
    finish_done();
    check_display(1234, 0, '0);
    run_load(2468, 0, 0);
    run_load(4321, 0, 0);
    finish_done();
    check_display(4321, 0, '0);

    for (int r = 0; r < 8; r++) begin
      rv       = $urandom_range(0, 16383);
      blank_lz = 1'($urandom);
      dp_mask  = DIGITS'($urandom);
      run_load(rv, 0, 0);
      finish_done();
      check_display(rv, blank_lz, dp_mask);
    end

    blank_lz = 1'b0;
    run_load(1234, 0, 0);
    finish_done();
    check_display(1234, 0, dp_mask);
    value = VALUE_W'(4321);
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_sel", digit_sel, 0);
    check("abort_seg", segment_data, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    rst_n = 1'b1;
    done_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done !== 1'b0) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    check_display(0, 0, dp_mask);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
